mux64_4_2: RTL and testbench
============================

Name: mux64_4_2

Overview:
- 4-to-1 multiplexer: 64-bit data (WIDTH), 2-bit select.
- Combinational data path routes the selected input to z with zero latency.
- A small registered side path gives a captured copy of the output and the select, plus a change flag, for downstream timing-closed consumers.
- Sits in the datapath wherever one of four equal-width buses must be steered.

Parameters:
- WIDTH, 64, data width of y0..y3, z and z_q.

Ports:
- clk  input  1  single clock; all registered outputs update on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- y0  input  WIDTH  data input, selected when x=2'b00.
- y1  input  WIDTH  data input, selected when x=2'b01.
- y2  input  WIDTH  data input, selected when x=2'b10.
- y3  input  WIDTH  data input, selected when x=2'b11.
- x  input  2  select.
- z  output  WIDTH  selected data; combinational unless the optional feature is enabled.
- z_q  output  WIDTH  registered copy of the selected data.
- sel_q  output  2  registered copy of x.
- z_chg  output  1  registered flag: high for one cycle when the newly captured z_q differs from its previous value.

Behaviour:
- z = y[x], bit for bit.
- No cross-bit leakage: each z[i] depends only on y0[i]..y3[i] and x.
- Unselected inputs never affect z.
- z settles within the same delta/combinational evaluation; no clock involvement.
- If x contains X/Z (simulation), z = all zeros (defined default arm). The synthesised result is don't-care.
- Registered path, on posedge clk:
  - z_q <= mux result.
  - sel_q <= x.
  - z_chg <= (mux result != z_q).
- Reset, when rst_n=0 (asynchronous, immediate):
  - z_q = 0, sel_q = 2'b00, z_chg = 0.
  - z stays combinational and unaffected by reset (default build).
- Reset deassertion: the first capture happens on the first rising clk edge with rst_n=1.
  - z_chg on that edge is 1 only if the mux result is non-zero.
- Select changing every cycle is legal: z follows immediately; z_q and sel_q follow one cycle later.
- Simultaneous change of x and the y inputs: z reflects the new pair; z_q captures the pair present at the edge.
- Width rules: no arithmetic; all buses are exactly WIDTH bits and there is no sign or zero extension.

Optional Feature:
- Macro: MUX64_4_2_OUT_REG_EN.
- Defined: z is driven from z_q.
  - 1-cycle latency.
  - z resets to 0 asynchronously with rst_n.
- Undefined (default): z is purely combinational, with zero latency.
- z_q, sel_q and z_chg behave identically in both builds.

Decomposition:
- Shared package mux64_4_2_pkg:
  - WIDTH default constant.
  - Select encodings: SEL_Y0=2'b00, SEL_Y1=2'b01, SEL_Y2=2'b10, SEL_Y3=2'b11.
  - Typedef for the 2-bit select.
- One sub-module: mux4_slice.
  - Parameterised-width 4:1 combinational mux with the default-zero arm.
  - Instantiated once for the data path.
- The top level adds the registers and the compare for z_chg.

Test Plan:
- Walking one: for sel in 0..3 and bit i in 0..63, set only y_sel[i]=1, all other inputs 0, x=sel. After #1, z = exactly 1<<i; 256 checks, 0 failures.
- Isolation: y0=AAAA_AAAA_AAAA_AAAA, y1=5555_5555_5555_5555, y2=FFFF_0000_FFFF_0000, y3=0123_4567_89AB_CDEF. Sweep x=0..3 and require z equal to each respective value. Then toggle each unselected input and require z unchanged.
- Reset: hold rst_n=0 mid-simulation, asynchronously between clock edges.
  - Require z_q=0, sel_q=0, z_chg=0 immediately.
  - Release reset with x=2, y2=1. The next edge gives z_q=1, sel_q=2, z_chg=1.
- Registered path: keep x=1, y1=DEAD_BEEF_0000_0001 for two edges.
  - z_chg=1, then 0.
  - Change to x=3 with y3 equal to the same value: z_chg stays 0 and sel_q becomes 3.
- Unknown select: x=2'bxx with all y non-zero -> z = 0.
- MUX64_4_2_OUT_REG_EN build: with x=0, y0=42, z=0 until the first post-reset edge, then 42. Changing x=1 with y1=7 updates z one cycle later.

Source files
------------

// File: rtl/mux64_4_2_pkg.sv
// ============================================================================
// Module      : mux64_4_2_pkg
// Description : Shared constants and select typedef for the mux64_4_2 block.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mux64_4_2_pkg;

  localparam int WIDTH_DEFAULT = 64;
  localparam int SEL_W         = 2;

  typedef enum logic [SEL_W-1:0] {
    SEL_Y0 = 2'b00,
    SEL_Y1 = 2'b01,
    SEL_Y2 = 2'b10,
    SEL_Y3 = 2'b11
  } sel_t;

endpackage

`default_nettype wire

// File: rtl/mux4_slice.sv
// ============================================================================
// Module      : mux4_slice
// Description : Parameterised-width 4:1 combinational mux, zero on unknown select.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mux4_slice
  import mux64_4_2_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic [WIDTH-1:0] y0,
  input  logic [WIDTH-1:0] y1,
  input  logic [WIDTH-1:0] y2,
  input  logic [WIDTH-1:0] y3,
  input  logic [SEL_W-1:0] sel,
  output logic [WIDTH-1:0] z
);

  // Case items match exactly, so an X/Z select falls to the zero arm.
  always_comb begin
    z = '0;
    case (sel)
      SEL_Y0:  z = y0;
      SEL_Y1:  z = y1;
      SEL_Y2:  z = y2;
      SEL_Y3:  z = y3;
      default: z = '0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mux64_4_2.sv
// ============================================================================
// Module      : mux64_4_2
// Description : 4:1 WIDTH-bit mux with a registered copy of output/select and
//               a change flag. Option macro: MUX64_4_2_OUT_REG_EN (z from z_q).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mux64_4_2
  import mux64_4_2_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] y0,
  input  logic [WIDTH-1:0] y1,
  input  logic [WIDTH-1:0] y2,
  input  logic [WIDTH-1:0] y3,
  input  logic [1:0]       x,
  output logic [WIDTH-1:0] z,
  output logic [WIDTH-1:0] z_q,
  output logic [1:0]       sel_q,
  output logic             z_chg
);

  logic [WIDTH-1:0] mux_out;

  mux4_slice #(
    .WIDTH (WIDTH)
  ) u_slice (
    .y0  (y0),
    .y1  (y1),
    .y2  (y2),
    .y3  (y3),
    .sel (x),
    .z   (mux_out)
  );

  // z_chg compares against the value z_q held before this capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      z_q   <= '0;
      sel_q <= SEL_Y0;
      z_chg <= 1'b0;
    end else begin
      z_q   <= mux_out;
      sel_q <= x;
      z_chg <= (mux_out != z_q);
    end
  end

`ifdef MUX64_4_2_OUT_REG_EN
  assign z = z_q;
`else
  assign z = mux_out;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mux64_4_2.sv
// ============================================================================
// Module      : tb_mux64_4_2
// Description : Self-checking bench for mux64_4_2 (either MUX64_4_2_OUT_REG_EN build).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mux64_4_2;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] ybus [4];
  logic [1:0]  x     = 2'b00;
  logic [63:0] z, z_q;
  logic [1:0]  sel_q;
  logic        z_chg;

  int errors = 0;
  int checks = 0;

  // Captured history: every rising edge out of reset appends the selected word.
  logic [63:0] cap [$];
  logic [1:0]  last_sel;

  always #5 clk = ~clk;

  mux64_4_2 #(.WIDTH(64)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .y0    (ybus[0]),
    .y1    (ybus[1]),
    .y2    (ybus[2]),
    .y3    (ybus[3]),
    .x     (x),
    .z     (z),
    .z_q   (z_q),
    .sel_q (sel_q),
    .z_chg (z_chg)
  );

  function automatic logic [63:0] ref_mux(input logic [1:0] s);
    if ($isunknown(s)) return 64'd0;
    return ybus[s];
  endfunction

  function automatic logic [63:0] exp_z();
`ifdef MUX64_4_2_OUT_REG_EN
    return cap[$];
`else
    return ref_mux(x);
`endif
  endfunction

  function automatic logic exp_chg();
    if (cap.size() < 2) return 1'b0;
    return cap[$] != cap[$-1];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap.delete();
      cap.push_back(64'd0);
      last_sel = 2'b00;
    end else begin
      cap.push_back(ref_mux(x));
      last_sel = x;
    end
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Let z settle: immediate in the combinational build, one edge in the registered build.
  task automatic settle();
`ifdef MUX64_4_2_OUT_REG_EN
    @(posedge clk); #1;
`else
    #1;
`endif
  endtask

  task automatic check_regs(input string tag);
    check_val({tag, "_zq"},  z_q,           cap[$]);
    check_val({tag, "_sel"}, 64'(sel_q),    64'(last_sel));
    check_val({tag, "_chg"}, 64'(z_chg),    64'(exp_chg()));
  endtask

  logic [63:0] iso [4];
  logic [63:0] hold;

  initial begin
    cap.push_back(64'd0);
    last_sel = 2'b00;
    for (int k = 0; k < 4; k++) ybus[k] = 64'd0;

    // Reset state
    #12;
    check_val("rst_zq",  z_q,          64'd0);
    check_val("rst_sel", 64'(sel_q),   64'd0);
    check_val("rst_chg", 64'(z_chg),   64'd0);
    check_val("rst_z",   z,            64'd0);
    @(negedge clk); rst_n = 1'b1;

    // Walking one through every select and bit
    for (int s = 0; s < 4; s++) begin
      for (int i = 0; i < 64; i++) begin
        @(negedge clk);
        for (int k = 0; k < 4; k++) ybus[k] = 64'd0;
        ybus[s] = 64'd1 << i;
        x = 2'(s);
        settle();
        check_val("walk1", z, 64'd1 << i);
      end
    end

    // Isolation: unselected inputs must not disturb z
    iso[0] = 64'hAAAA_AAAA_AAAA_AAAA;
    iso[1] = 64'h5555_5555_5555_5555;
    iso[2] = 64'hFFFF_0000_FFFF_0000;
    iso[3] = 64'h0123_4567_89AB_CDEF;
    for (int s = 0; s < 4; s++) begin
      @(negedge clk);
      for (int k = 0; k < 4; k++) ybus[k] = iso[k];
      x = 2'(s);
      settle();
      check_val("iso_sel", z, iso[s]);
      for (int j = 0; j < 4; j++) begin
        if (j != s) begin
          @(negedge clk);
          ybus[j] = ~ybus[j];
          settle();
          check_val("iso_toggle", z, iso[s]);
        end
      end
    end

    // Asynchronous reset between edges, then first capture after release
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    check_val("arst_zq",  z_q,        64'd0);
    check_val("arst_sel", 64'(sel_q), 64'd0);
    check_val("arst_chg", 64'(z_chg), 64'd0);
    for (int k = 0; k < 4; k++) ybus[k] = 64'd0;
    ybus[2] = 64'd1;
    x = 2'd2;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check_val("rel_zq",  z_q,        64'd1);
    check_val("rel_sel", 64'(sel_q), 64'd2);
    check_val("rel_chg", 64'(z_chg), 64'd1);

    // Holding the same word clears the change flag; same word on another input too
    @(negedge clk);
    x = 2'd1; ybus[1] = 64'hDEAD_BEEF_0000_0001;
    @(posedge clk); #1;
    check_val("hold1_chg", 64'(z_chg), 64'd1);
    check_val("hold1_zq",  z_q,        64'hDEAD_BEEF_0000_0001);
    @(posedge clk); #1;
    check_val("hold2_chg", 64'(z_chg), 64'd0);
    @(negedge clk);
    x = 2'd3; ybus[3] = 64'hDEAD_BEEF_0000_0001;
    @(posedge clk); #1;
    check_val("same_chg", 64'(z_chg), 64'd0);
    check_val("same_sel", 64'(sel_q), 64'd3);

    // Unknown select
    @(negedge clk);
    for (int k = 0; k < 4; k++) ybus[k] = {$urandom, $urandom} | 64'd1;
    x = 2'bxx;
    settle();
    check_val("xsel_z", z, exp_z());
    @(negedge clk); x = 2'd0;

    // Randomized traffic against the capture history
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if ($urandom_range(0, 3) != 0) begin
        for (int k = 0; k < 4; k++) ybus[k] = {$urandom, $urandom};
        if ($urandom_range(0, 7) == 0) ybus[$urandom_range(0, 3)] = ybus[x];
      end
      if ($urandom_range(0, 2) != 0) x = 2'($urandom_range(0, 3));
      #1;
      check_val("rnd_z_pre", z, exp_z());
      @(posedge clk); #1;
      check_regs("rnd");
      check_val("rnd_z_post", z, exp_z());
    end

    // Output latency around reset and a select change
    @(negedge clk);
    rst_n = 1'b0;
    x = 2'd0;
    for (int k = 0; k < 4; k++) ybus[k] = 64'd0;
    ybus[0] = 64'd42;
    ybus[1] = 64'd7;
    #1;
`ifdef MUX64_4_2_OUT_REG_EN
    hold = 64'd0;
`else
    hold = 64'd42;
`endif
    check_val("lat_rst_z", z, hold);
    @(negedge clk); rst_n = 1'b1;
    #1;
    check_val("lat_rel_z", z, hold);
    @(posedge clk); #1;
    check_val("lat_edge_z", z, 64'd42);
    @(negedge clk); x = 2'd1;
    #1;
`ifdef MUX64_4_2_OUT_REG_EN
    hold = 64'd42;
`else
    hold = 64'd7;
`endif
    check_val("lat_sel_z", z, hold);
    @(posedge clk); #1;
    check_val("lat_sel_edge_z", z, 64'd7);
    check_regs("lat");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
